// File: rtl/mbldcm_ramp_sequencer_if.sv
// Control/core bundle for the BLDC ramp sequencer.
// The master side is the CPU/register side. The slave side is the sequencer itself.
interface mbldcm_ramp_sequencer_if #(
  parameter int pIntervalWidth = 16
);
  logic                      iStart;
  logic                      iStopReq;
  logic [31:0]               iStartDiv;
  logic [31:0]               iTargetDiv;
  logic [31:0]               iStepDiv;
  logic [pIntervalWidth-1:0] iInterval;
  logic [31:0]               iAlignCycles;
  logic                      oEnable;
  logic [31:0]               oDiv;
  logic                      oStop;
  logic [3:0]                oPhaseUpdate;
  logic                      oLatchPhaseUpdate;
  logic [2:0]                oState;
  logic                      oBusy;
  logic                      oAtSpeed;

  modport master (
    output iStart, iStopReq, iStartDiv, iTargetDiv, iStepDiv, iInterval, iAlignCycles,
    input  oEnable, oDiv, oStop, oPhaseUpdate, oLatchPhaseUpdate, oState, oBusy, oAtSpeed
  );

  modport slave (
    input  iStart, iStopReq, iStartDiv, iTargetDiv, iStepDiv, iInterval, iAlignCycles,
    output oEnable, oDiv, oStop, oPhaseUpdate, oLatchPhaseUpdate, oState, oBusy, oAtSpeed
  );
endinterface

// File: rtl/mbldcm_ramp_sequencer.sv
// Start/stop sequencer for the BLDC core: align, accelerate, run, and optionally decelerate.
// Optional feature macro MBLDCM_RAMP_DECEL_EN: the stop request decelerates instead of cutting the drive.
module mbldcm_ramp_sequencer #(
  parameter int pIntervalWidth = 16
) (
  input logic                    iClock,
  input logic                    iReset_n,
  mbldcm_ramp_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    sIdle  = 3'd0,
    sAlign = 3'd1,
    sRamp  = 3'd2,
    sRun   = 3'd3,
    sDecel = 3'd4
  } tState;

  localparam logic [31:0] cDivIdle = 32'hFFFF_FFFF;

  tState                     state;
  logic                      enable;
  logic                      stop;
  logic                      latchPhase;
  logic [31:0]               div;
  logic [31:0]               startDiv;
  logic [31:0]               targetDiv;
  logic [31:0]               stepDiv;
  logic [pIntervalWidth-1:0] intervalCfg;
  logic [31:0]               alignCfg;
  logic [31:0]               alignCnt;
  logic [pIntervalWidth-1:0] intervalCnt;

  logic [pIntervalWidth-1:0] intervalEff;
  logic [31:0]               alignLast;
  logic                      tick;
  logic                      rampDone;
  logic                      decelDone;
  logic                      stopNow;

  // Zero-length settings are promoted to one cycle, so the sequence always advances.
  assign intervalEff = (intervalCfg == '0) ? pIntervalWidth'(1) : intervalCfg;
  assign alignLast   = (alignCfg == 32'd0) ? 32'd0 : alignCfg - 32'd1;
  assign tick        = (intervalCnt <= pIntervalWidth'(1));
  // The compares use 33 bits, so a sum near 2^32 cannot wrap and end the ramp early.
  assign rampDone    = ({1'b0, div} <= ({1'b0, targetDiv} + {1'b0, stepDiv}));
  assign decelDone   = (({1'b0, div} + {1'b0, stepDiv}) >= {1'b0, startDiv});
  assign stopNow     = bus.iStopReq && (state == sAlign || state == sRamp || state == sRun);

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state       <= sIdle;
      enable      <= 1'b0;
      stop        <= 1'b1;
      latchPhase  <= 1'b0;
      div         <= cDivIdle;
      startDiv    <= '0;
      targetDiv   <= '0;
      stepDiv     <= '0;
      intervalCfg <= '0;
      alignCfg    <= '0;
      alignCnt    <= '0;
      intervalCnt <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
      latchPhase <= 1'b0;
      if (stopNow) begin
`ifdef MBLDCM_RAMP_DECEL_EN
        state       <= sDecel;
        stop        <= 1'b0;
        intervalCnt <= intervalEff;
`else
        state  <= sIdle;
        enable <= 1'b0;
        stop   <= 1'b1;
        div    <= cDivIdle;
`endif
      end else begin
        case (state)
          sIdle: begin
            if (bus.iStart && !bus.iStopReq) begin
              startDiv    <= bus.iStartDiv;
              targetDiv   <= bus.iTargetDiv;
              stepDiv     <= bus.iStepDiv;
              intervalCfg <= bus.iInterval;
              alignCfg    <= bus.iAlignCycles;
              alignCnt    <= '0;
              enable      <= 1'b1;
              stop        <= 1'b1;
              div         <= bus.iStartDiv;
              latchPhase  <= 1'b1;
              state       <= sAlign;
            end
          end
          sAlign: begin
            if (alignCnt >= alignLast) begin
              stop        <= 1'b0;
              intervalCnt <= intervalEff;
              state       <= sRamp;
            end else begin
              alignCnt <= alignCnt + 32'd1;
            end
          end
          sRamp: begin
            if (tick) begin
              if (rampDone) begin
                div   <= targetDiv;
                state <= sRun;
              end else begin
                div         <= div - stepDiv;
                intervalCnt <= intervalEff;
              end
            end else begin
              intervalCnt <= intervalCnt - pIntervalWidth'(1);
            end
          end
          sRun: ;
          sDecel: begin
            if (tick) begin
              if (decelDone) begin
                state  <= sIdle;
                enable <= 1'b0;
                stop   <= 1'b1;
                div    <= cDivIdle;
              end else begin
                div         <= div + stepDiv;
                intervalCnt <= intervalEff;
              end
            end else begin
              intervalCnt <= intervalCnt - pIntervalWidth'(1);
            end
          end
          default: state <= sIdle;
        endcase
      end
    end
  end

  assign bus.oEnable           = enable;
  assign bus.oDiv              = div;
  assign bus.oStop             = stop;
  assign bus.oPhaseUpdate      = 4'd0;
  assign bus.oLatchPhaseUpdate = latchPhase;
  assign bus.oState            = state;
  assign bus.oBusy             = (state != sIdle);
  assign bus.oAtSpeed          = (state == sRun);
endmodule

// File: tb/tb_mbldcm_ramp_sequencer.sv
// Directed bench for mbldcm_ramp_sequencer, covering both builds of MBLDCM_RAMP_DECEL_EN.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_mbldcm_ramp_sequencer;
  logic iClock = 1'b0;
  logic iReset_n = 1'b0;
  int   nChecks = 0;
  int   nFails = 0;

  mbldcm_ramp_sequencer_if #(.pIntervalWidth(16)) bus ();

  mbldcm_ramp_sequencer #(.pIntervalWidth(16)) dut (
    .iClock  (iClock),
    .iReset_n(iReset_n),
    .bus     (bus.slave)
  );

  always #5 iClock = ~iClock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge iClock);
  endtask

  task automatic configure(input logic [31:0] s, input logic [31:0] t, input logic [31:0] st,
                           input logic [15:0] iv, input logic [31:0] al);
    bus.iStartDiv    = s;
    bus.iTargetDiv   = t;
    bus.iStepDiv     = st;
    bus.iInterval    = iv;
    bus.iAlignCycles = al;
  endtask

  task automatic pulseStart();
    bus.iStart = 1'b1;
    @(negedge iClock);
    bus.iStart = 1'b0;
  endtask

  task automatic pulseStop();
    bus.iStopReq = 1'b1;
    @(negedge iClock);
    bus.iStopReq = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, ".state"},  {29'd0, bus.oState}, 32'd0);
    check({tag, ".enable"}, {31'd0, bus.oEnable}, 32'd0);
    check({tag, ".stop"},   {31'd0, bus.oStop}, 32'd1);
    check({tag, ".div"},    bus.oDiv, 32'hFFFF_FFFF);
  endtask

  initial begin
    bus.iStart   = 1'b0;
    bus.iStopReq = 1'b0;
    configure(32'd0, 32'd0, 32'd0, 16'd0, 32'd0);
    cycles(3);

    checkIdle("reset");
    check("reset.busy",    {31'd0, bus.oBusy}, 32'd0);
    check("reset.atSpeed", {31'd0, bus.oAtSpeed}, 32'd0);
    check("reset.latch",   {31'd0, bus.oLatchPhaseUpdate}, 32'd0);
    check("reset.phase",   {28'd0, bus.oPhaseUpdate}, 32'd0);
    iReset_n = 1'b1;
    cycles(1);

    // Start and stop together in IDLE: the stop wins.
    configure(32'd1000, 32'd400, 32'd200, 16'd4, 32'd3);
    bus.iStart   = 1'b1;
    bus.iStopReq = 1'b1;
    cycles(1);
    bus.iStart   = 1'b0;
    bus.iStopReq = 1'b0;
    check("both.state", {29'd0, bus.oState}, 32'd0);
    check("both.enable", {31'd0, bus.oEnable}, 32'd0);
    cycles(1);

    // Nominal ramp 1000 -> 400 with step 200, interval 4, align 3.
    pulseStart();
    check("nom.alignState", {29'd0, bus.oState}, 32'd1);
    check("nom.alignEnable", {31'd0, bus.oEnable}, 32'd1);
    check("nom.alignStop", {31'd0, bus.oStop}, 32'd1);
    check("nom.alignDiv", bus.oDiv, 32'd1000);
    check("nom.latchHigh", {31'd0, bus.oLatchPhaseUpdate}, 32'd1);
    check("nom.busy", {31'd0, bus.oBusy}, 32'd1);
    cycles(1);
    check("nom.latchLow", {31'd0, bus.oLatchPhaseUpdate}, 32'd0);
    cycles(1);
    check("nom.alignLast", {29'd0, bus.oState}, 32'd1);
    check("nom.alignStopLast", {31'd0, bus.oStop}, 32'd1);
    cycles(1);
    check("nom.rampState", {29'd0, bus.oState}, 32'd2);
    check("nom.rampStop", {31'd0, bus.oStop}, 32'd0);
    cycles(3);
    check("nom.preTick1", bus.oDiv, 32'd1000);
    cycles(1);
    check("nom.tick1", bus.oDiv, 32'd800);
    cycles(4);
    check("nom.tick2", bus.oDiv, 32'd600);
    cycles(3);
    check("nom.preTick3State", {29'd0, bus.oState}, 32'd2);
    check("nom.preTick3AtSpeed", {31'd0, bus.oAtSpeed}, 32'd0);
    cycles(1);
    check("nom.tick3Div", bus.oDiv, 32'd400);
    check("nom.runState", {29'd0, bus.oState}, 32'd3);
    check("nom.atSpeed", {31'd0, bus.oAtSpeed}, 32'd1);

    // A start request during RUN is ignored.
    configure(32'd2000, 32'd100, 32'd50, 16'd2, 32'd1);
    pulseStart();
    check("ignStart.state", {29'd0, bus.oState}, 32'd3);
    check("ignStart.div", bus.oDiv, 32'd400);
    check("ignStart.latch", {31'd0, bus.oLatchPhaseUpdate}, 32'd0);

    pulseStop();
`ifdef MBLDCM_RAMP_DECEL_EN
    check("dec.state", {29'd0, bus.oState}, 32'd4);
    check("dec.atSpeed", {31'd0, bus.oAtSpeed}, 32'd0);
    check("dec.enable", {31'd0, bus.oEnable}, 32'd1);
    check("dec.stop", {31'd0, bus.oStop}, 32'd0);
    check("dec.div0", bus.oDiv, 32'd400);
    cycles(4);
    check("dec.tick1", bus.oDiv, 32'd600);
    pulseStop();
    cycles(3);
    check("dec.tick2", bus.oDiv, 32'd800);
    cycles(3);
    check("dec.preEnd", {29'd0, bus.oState}, 32'd4);
    cycles(1);
    checkIdle("dec.end");
`else
    checkIdle("runStop");
    check("runStop.atSpeed", {31'd0, bus.oAtSpeed}, 32'd0);
`endif
    cycles(2);

    // Degenerate settings: zero interval and align, start already below target.
    configure(32'd300, 32'd500, 32'd10, 16'd0, 32'd0);
    pulseStart();
    configure(32'd9, 32'd7, 32'd1, 16'd5, 32'd5);
    check("deg.align", {29'd0, bus.oState}, 32'd1);
    cycles(1);
    check("deg.ramp", {29'd0, bus.oState}, 32'd2);
    check("deg.rampDiv", bus.oDiv, 32'd300);
    cycles(1);
    check("deg.run", {29'd0, bus.oState}, 32'd3);
    check("deg.runDiv", bus.oDiv, 32'd500);
    pulseStop();
`ifdef MBLDCM_RAMP_DECEL_EN
    check("deg.decel", {29'd0, bus.oState}, 32'd4);
    cycles(1);
    checkIdle("deg.end");
`else
    checkIdle("deg.stop");
`endif
    cycles(2);

    // Stop request in the middle of RAMP.
    configure(32'd1000, 32'd400, 32'd200, 16'd4, 32'd3);
    pulseStart();
    cycles(5);
    check("rampStop.pre", {29'd0, bus.oState}, 32'd2);
    pulseStop();
`ifdef MBLDCM_RAMP_DECEL_EN
    check("rampStop.state", {29'd0, bus.oState}, 32'd4);
    check("rampStop.div", bus.oDiv, 32'd1000);
    cycles(3);
    check("rampStop.hold", {29'd0, bus.oState}, 32'd4);
    cycles(1);
    checkIdle("rampStop.end");
`else
    checkIdle("rampStop");
`endif
    cycles(2);

    // Asynchronous reset in the middle of RAMP, checked before any further clock edge.
    pulseStart();
    cycles(4);
    check("arst.pre", {29'd0, bus.oState}, 32'd2);
    #2 iReset_n = 1'b0;
    #1;
    checkIdle("arst");
    check("arst.busy", {31'd0, bus.oBusy}, 32'd0);
    cycles(2);
    iReset_n = 1'b1;
    cycles(2);
    check("arst.stay", {29'd0, bus.oState}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end
endmodule
